// File: rtl/membus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : membus_pkg
// Purpose  : Shared state encoding, one-hot grant constants and defaults for
//            the two-master memory-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package membus_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0]  GNT_NONE          = 2'b00;
    localparam logic [1:0]  GNT_M0            = 2'b01;
    localparam logic [1:0]  GNT_M1            = 2'b10;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/membus_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : membus_arb_pick
// Purpose  : Combinational two-way winner selection, round-robin or fixed
//            priority, producing a one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
module membus_arb_pick
    import membus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_m1,
    output logic [1:0] pick
);

    always_comb begin
        pick = GNT_NONE;
        if (valid0 && valid1) begin
            // Under round-robin the master not served last wins the tie.
            pick = ((ROUND_ROBIN != 0) && !last_m1) ? GNT_M1 : GNT_M0;
        end else if (valid0) begin
            pick = GNT_M0;
        end else if (valid1) begin
            pick = GNT_M1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : membus_arbiter
// Purpose  : Two-master arbiter for the valid/ready memory bus with
//            per-transaction grant locking. Optional watchdog enabled by
//            defining MEMBUS_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module membus_arbiter
    import membus_pkg::*;
#(
    parameter int          ROUND_ROBIN    = 1,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout
);

    localparam logic [15:0] c_WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_grant, w_grant_nxt;
    logic        r_last_m1, w_last_nxt;
    logic [1:0]  w_pick;
    logic        w_busy, w_gnt_valid, w_fire, w_done;
    logic [31:0] w_rdata_src;

    membus_arb_pick #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_pick (
        .valid0  (m0_valid),
        .valid1  (m1_valid),
        .last_m1 (r_last_m1),
        .pick    (w_pick)
    );

    assign w_busy      = (r_state == BUSY);
    assign w_gnt_valid = (r_grant[0] & m0_valid) | (r_grant[1] & m1_valid);

`ifdef MEMBUS_ARB_TIMEOUT_EN
    logic [15:0] r_wdog;

    // Held at zero while idle, so every transaction starts counting from 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wdog <= 16'd0;
        end else if (!w_busy) begin
            r_wdog <= 16'd0;
        end else if (!s_ready) begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    assign w_fire = w_busy & w_gnt_valid & ~s_ready & (r_wdog == c_WDOG_LAST);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^c_WDOG_LAST;
    assign w_fire       = 1'b0;
`endif

    // A completion needs the owner still requesting; otherwise it is an abort.
    assign w_done = w_busy & w_gnt_valid & (s_ready | w_fire);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_grant   <= GNT_NONE;
            r_last_m1 <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last_m1 <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_m1;
        case (r_state)
            IDLE: begin
                if (w_pick != GNT_NONE) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_pick;
                end
            end
            BUSY: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = GNT_NONE;
                    w_last_nxt  = r_grant[1];
                end else if (!w_gnt_valid) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = GNT_NONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = GNT_NONE;
            end
        endcase
    end

    always_comb begin
        s_wstrb = 4'h0;
        s_addr  = 32'h0;
        s_wdata = 32'h0;
        if (r_grant == GNT_M0) begin
            s_wstrb = m0_wstrb;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
        end else if (r_grant == GNT_M1) begin
            s_wstrb = m1_wstrb;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end
    end

    assign w_rdata_src = w_fire ? ERR_RDATA : s_rdata;
    assign s_valid     = w_busy & w_gnt_valid & ~w_fire;
    assign m0_ready    = r_grant[0] & w_done;
    assign m1_ready    = r_grant[1] & w_done;
    assign m0_rdata    = r_grant[0] ? w_rdata_src : 32'h0;
    assign m1_rdata    = r_grant[1] ? w_rdata_src : 32'h0;
    assign grant       = r_grant;
    assign timeout     = w_fire;

endmodule
`default_nettype wire

// File: tb/tb_membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_membus_arbiter
// Purpose  : Self-checking bench; a round-robin and a fixed-priority arbiter
//            share stimulus and are compared against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_membus_arbiter;

    localparam int T = 8;
`ifdef MEMBUS_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid, s_ready;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;

    logic        dut_m0_ready [2];
    logic        dut_m1_ready [2];
    logic [31:0] dut_m0_rdata [2];
    logic [31:0] dut_m1_rdata [2];
    logic        dut_s_valid  [2];
    logic [3:0]  dut_s_wstrb  [2];
    logic [31:0] dut_s_addr   [2];
    logic [31:0] dut_s_wdata  [2];
    logic [1:0]  dut_grant    [2];
    logic        dut_timeout  [2];

    int checks   = 0;
    int failures = 0;
    int owner [2];
    int last  [2];
    int cnt   [2];
    bit rr_done [2];

    always #5 clk = ~clk;

    membus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(T)) u_rr (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(dut_m0_ready[0]), .m0_rdata(dut_m0_rdata[0]),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(dut_m1_ready[0]), .m1_rdata(dut_m1_rdata[0]),
        .s_valid(dut_s_valid[0]), .s_wstrb(dut_s_wstrb[0]), .s_addr(dut_s_addr[0]),
        .s_wdata(dut_s_wdata[0]), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(dut_grant[0]), .timeout(dut_timeout[0])
    );

    membus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(T)) u_fp (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(dut_m0_ready[1]), .m0_rdata(dut_m0_rdata[1]),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(dut_m1_ready[1]), .m1_rdata(dut_m1_rdata[1]),
        .s_valid(dut_s_valid[1]), .s_wstrb(dut_s_wstrb[1]), .s_addr(dut_s_addr[1]),
        .s_wdata(dut_s_wdata[1]), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(dut_grant[1]), .timeout(dut_timeout[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit gvalid(input int o);
        if (o == 0) return m0_valid;
        if (o == 1) return m1_valid;
        return 1'b0;
    endfunction

    // Watchdog expiry: owner still requesting, no slave ready, T-th busy cycle.
    function automatic bit fire_of(input int d);
        return TMO && (owner[d] >= 0) && gvalid(owner[d]) && !s_ready && (cnt[d] == T - 1);
    endfunction

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            string       p;
            int          o;
            bit          gv, fire, done;
            logic [31:0] rd, ea, ew;
            logic [3:0]  es;
            p    = (d == 0) ? "rr" : "fp";
            o    = owner[d];
            gv   = gvalid(o);
            fire = fire_of(d);
            done = (o >= 0) && gv && (s_ready || fire);
            rd   = fire ? 32'hDEAD_BEEF : s_rdata;
            es   = (o == 0) ? m0_wstrb : (o == 1) ? m1_wstrb : 4'h0;
            ea   = (o == 0) ? m0_addr  : (o == 1) ? m1_addr  : 32'h0;
            ew   = (o == 0) ? m0_wdata : (o == 1) ? m1_wdata : 32'h0;
            check_eq({p, ".grant"},    32'(dut_grant[d]),    (o < 0) ? 32'd0 : (o == 0) ? 32'd1 : 32'd2);
            check_eq({p, ".s_valid"},  32'(dut_s_valid[d]),  32'((o >= 0) && gv && !fire));
            check_eq({p, ".s_wstrb"},  32'(dut_s_wstrb[d]),  32'(es));
            check_eq({p, ".s_addr"},   dut_s_addr[d],        ea);
            check_eq({p, ".s_wdata"},  dut_s_wdata[d],       ew);
            check_eq({p, ".m0_ready"}, 32'(dut_m0_ready[d]), 32'(done && o == 0));
            check_eq({p, ".m1_ready"}, 32'(dut_m1_ready[d]), 32'(done && o == 1));
            check_eq({p, ".m0_rdata"}, dut_m0_rdata[d],      (o == 0) ? rd : 32'h0);
            check_eq({p, ".m1_rdata"}, dut_m1_rdata[d],      (o == 1) ? rd : 32'h0);
            check_eq({p, ".timeout"},  32'(dut_timeout[d]),  32'(fire));
            if (d == 0) begin
                rr_done[0] = done && (o == 0);
                rr_done[1] = done && (o == 1);
            end
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int o;
            bit gv, fire;
            o    = owner[d];
            gv   = gvalid(o);
            fire = fire_of(d);
            if (!resetn) begin
                owner[d] = -1; last[d] = 1; cnt[d] = 0;
            end else if (o < 0) begin
                if (m0_valid && m1_valid) owner[d] = (d == 0) ? 1 - last[d] : 0;
                else if (m0_valid)        owner[d] = 0;
                else if (m1_valid)        owner[d] = 1;
                cnt[d] = 0;
            end else if (gv && (s_ready || fire)) begin
                last[d]  = o;
                owner[d] = -1;
            end else if (!gv) begin
                owner[d] = -1;
            end else begin
                cnt[d]++;
            end
        end
    endtask

    task automatic settle();
        #2;
        compare();
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_ready  = 1'b0; s_rdata  = 32'h0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        settle();
        adv();
        resetn = 1'b1;
    endtask

    task automatic master_update(input bit done, input bit cur_v, output bit nv, output bit renew);
        if (cur_v && !done) begin
            nv    = ($urandom_range(0, 31) != 0);
            renew = 1'b0;
        end else begin
            nv    = 1'($urandom_range(0, 1));
            renew = nv;
        end
    endtask

    initial begin
        bit v, r;
        owner = '{-1, -1};
        last  = '{1, 1};
        cnt   = '{0, 0};
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        adv();
        resetn = 1'b1;

        // Reset state, then a lone m0 read answered one cycle after s_valid.
        m0_valid = 1'b1; m0_addr = 32'h0000_0010;
        settle();
        check_eq("read.idle_sval", 32'(dut_s_valid[0]), 32'd0);
        adv();
        settle();
        check_eq("read.sval", 32'(dut_s_valid[0]), 32'd1);
        check_eq("read.addr", dut_s_addr[0], 32'h0000_0010);
        adv();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        settle();
        check_eq("read.ready", 32'(dut_m0_ready[0]), 32'd1);
        check_eq("read.rdata", dut_m0_rdata[0], 32'h1234_5678);
        check_eq("read.m1rdy", 32'(dut_m1_ready[0]), 32'd0);
        adv();
        m0_valid = 1'b0; s_ready = 1'b0;
        settle();
        check_eq("read.pulse", 32'(dut_m0_ready[0]), 32'd0);
        adv();

        // m1 write routing; transaction left hanging for the reset test.
        m1_valid = 1'b1; m1_wstrb = 4'b0011; m1_addr = 32'h0200_0004; m1_wdata = 32'hAABB_CCDD;
        settle();
        adv();
        settle();
        check_eq("wr.grant", 32'(dut_grant[0]), 32'd2);
        check_eq("wr.wstrb", 32'(dut_s_wstrb[0]), 32'h3);
        check_eq("wr.addr",  dut_s_addr[0], 32'h0200_0004);
        check_eq("wr.wdata", dut_s_wdata[0], 32'hAABB_CCDD);
        adv();
        settle();
        adv();

        // Reset while m1 is busy; last-served returns to m1 so m0 wins next.
        resetn = 1'b0;
        settle();
        adv();
        resetn = 1'b1;
        m0_valid = 1'b1;
        settle();
        check_eq("rst.grant", 32'(dut_grant[0]), 32'd0);
        check_eq("rst.sval",  32'(dut_s_valid[0]), 32'd0);
        check_eq("rst.m1rdy", 32'(dut_m1_ready[0]), 32'd0);
        adv();
        settle();
        check_eq("rst.win", 32'(dut_grant[0]), 32'd1);
        adv();

        // Continuous contention with an always-ready slave.
        idle_inputs();
        do_reset();
        m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (i % 2 == 0) begin
                check_eq("rr.gap_grant", 32'(dut_grant[0]), 32'd0);
                check_eq("rr.gap_sval",  32'(dut_s_valid[0]), 32'd0);
            end else begin
                check_eq("rr.seq", 32'(dut_grant[0]), ((i / 2) % 2 == 0) ? 32'd1 : 32'd2);
                check_eq("fp.seq", 32'(dut_grant[1]), 32'd1);
            end
            adv();
        end
        idle_inputs();
        do_reset();

`ifdef MEMBUS_ARB_TIMEOUT_EN
        // Silent slave: watchdog answers in the 8th busy cycle.
        m0_valid = 1'b1;
        settle();
        adv();
        for (int b = 1; b <= T; b++) begin
            settle();
            if (b == T) begin
                check_eq("tmo.ready", 32'(dut_m0_ready[0]), 32'd1);
                check_eq("tmo.rdata", dut_m0_rdata[0], 32'hDEAD_BEEF);
                check_eq("tmo.pulse", 32'(dut_timeout[0]), 32'd1);
            end else begin
                check_eq("tmo.early", 32'(dut_timeout[0]), 32'd0);
            end
            adv();
        end
        m0_valid = 1'b0;
        settle();
        adv();
        // Slave answers in that same cycle: its data wins, no timeout.
        m0_valid = 1'b1;
        settle();
        adv();
        for (int b = 1; b <= T; b++) begin
            if (b == T) begin
                s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
            end
            settle();
            if (b == T) begin
                check_eq("tmo2.ready", 32'(dut_m0_ready[0]), 32'd1);
                check_eq("tmo2.rdata", dut_m0_rdata[0], 32'hCAFE_F00D);
                check_eq("tmo2.pulse", 32'(dut_timeout[0]), 32'd0);
            end
            adv();
        end
        idle_inputs();
        do_reset();
`endif

        // Randomised traffic with aborts and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            resetn = ($urandom_range(0, 99) != 0);
            master_update(rr_done[0], m0_valid, v, r);
            m0_valid = v;
            if (r) begin
                m0_wstrb = 4'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
            end
            master_update(rr_done[1], m1_valid, v, r);
            m1_valid = v;
            if (r) begin
                m1_wstrb = 4'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
            end
            s_ready = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
            settle();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/membus_arbiter.md
# membus_arbiter

Two-master arbiter for the native valid/ready memory bus. It shares one downstream bus port between two requesters: the CPU on master 0 and a DMA-capable datapath engine on master 1. It sits between the masters and the SoC address decoder, in front of the RAM, SPI flash, config registers and iomem. The block owns per-transaction grant locking, round-robin or fixed priority, and an optional bus-timeout watchdog.

## Interface
- ROUND_ROBIN, 1, 1 = round-robin between masters; 0 = master 0 always wins ties
- TIMEOUT_CYCLES, 255, watchdog limit in cycles, range 1..65535; used only with the timeout macro
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction
- clk  in  1  single clock, rising edge
- resetn  in  1  synchronous, active-low reset
- m0_valid / m1_valid  in  1  master request; held high until that master's ready
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 = read
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_ready / m1_ready  out  1  one-cycle completion pulse to the master
- m0_rdata / m1_rdata  out  32  read data, valid when the matching ready is high
- s_valid  out  1  downstream request
- s_wstrb, s_addr, s_wdata  out  4/32/32  muxed from the granted master
- s_ready  in  1  downstream completion
- s_rdata  in  32  downstream read data
- grant  out  2  one-hot current owner; 00 when idle
- timeout  out  1  one-cycle pulse when the watchdog fires

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if any m*_valid is high, register the winner into grant and go to BUSY. Otherwise stay in IDLE.
- Arbitration when both masters request:
  - ROUND_ROBIN=1: the master not served last wins. After reset the last-served master is 1, so master 0 wins first.
  - ROUND_ROBIN=0: master 0 wins.
- BUSY, combinational outputs:
  - s_valid = valid of the granted master.
  - s_wstrb, s_addr and s_wdata come from the granted master.
  - The granted master's ready equals s_ready and its rdata equals s_rdata.
  - The non-granted master sees ready=0 and rdata=0.
- BUSY exits to IDLE on any of:
  - s_ready high: record the last-served master and clear grant.
  - Granted master drops valid (abort): no ready is issued.
  - Watchdog fires (macro builds only).
- Grant is locked for the whole transaction. Master request lines are ignored for arbitration while in BUSY.
- Reset (resetn low at a clock edge), including mid-transaction:
  - state = IDLE, grant = 00, last-served = master 1, watchdog counter = 0.
  - m*_ready, s_valid and timeout read 0 in the cycle after the edge.

## Timing
- Reset values: s_valid 0, s_wstrb 0, s_addr 0, s_wdata 0, m*_ready 0, m*_rdata 0, grant 00, timeout 0.
- Arbitration latency is 1 cycle: request seen in cycle N gives s_valid high in cycle N+1.
- Ready path from s_ready to m*_ready is combinational, 0 cycles.
- After a completion, s_valid is low for at least one cycle (the IDLE cycle). This stops a downstream single-cycle responder from seeing a stale request.
- Back-to-back requests from one master: the minimum period is 2 cycles plus the slave latency.
- The s_* mux outputs are 0 whenever grant = 00.

## Configuration
- MEMBUS_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle while s_ready is low.
  - When the counter equals TIMEOUT_CYCLES-1 and s_ready is still low, in that cycle:
    - the granted master gets ready=1 and rdata=ERR_RDATA;
    - s_valid is forced to 0;
    - timeout pulses for one cycle.
  - FSM then returns to IDLE and last-served is updated.
  - If s_ready and the timeout condition occur in the same cycle, s_ready wins: rdata = s_rdata and no timeout pulse.
- MEMBUS_ARB_TIMEOUT_EN undefined:
  - No counter is built; timeout is tied to 0.
  - A BUSY transaction waits indefinitely for s_ready.

## Structure
- Shared package membus_pkg holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1);
  - the 2-bit one-hot grant constants GNT_NONE, GNT_M0, GNT_M1;
  - the ERR_RDATA default.
- One sub-module, membus_arb_pick: a combinational winner selection. Inputs are the two valids, last-served and ROUND_ROBIN; output is the one-hot grant. It is reusable for wider arbiters later.
- The watchdog stays inline under the macro.

## Test plan
- Single read, no contention:
  - Stimulus: m0 read at 0x0000_0010; slave asserts ready 1 cycle after s_valid with s_rdata=0x1234_5678.
  - Required: m0_rdata=0x1234_5678; m0_ready high exactly one cycle; total 3 cycles from m0_valid; m1_ready stays 0.
- Simultaneous requests with ROUND_ROBIN=1:
  - Stimulus: both masters hold valid through 4 transactions.
  - Required: grant sequence 01,10,01,10, with an IDLE cycle (grant=00, s_valid=0) between each.
- Fixed priority with ROUND_ROBIN=0:
  - Stimulus: both masters hold valid.
  - Required: m0 is served every transaction; m1 is never granted while m0_valid stays high.
- Write routing:
  - Stimulus: m1 writes wstrb=4'b0011, addr=0x0200_0004, wdata=0xAABB_CCDD.
  - Required: s_wstrb, s_addr and s_wdata match exactly while grant=10.
- Reset mid-transaction:
  - Stimulus: resetn low for 1 cycle while BUSY on m1.
  - Required: next cycle grant=00, s_valid=0, m1_ready=0. The next contention is won by m0.
- Timeout (macro defined, TIMEOUT_CYCLES=8):
  - Stimulus: slave never readies.
  - Required: after 8 BUSY cycles, m0_ready=1 with rdata=0xDEAD_BEEF and timeout pulses once. A second run where s_ready arrives in that same 8th cycle returns s_rdata with no timeout pulse.
